data_memory_ctrl: RTL
=====================

# data_memory_ctrl

Single-clock, parametrised successor to the CPU data memory. It provides one write port and one read port, with per-lane byte-write masking and a registered read of fixed 1-cycle latency. Same-cycle write-to-read forwarding is built in, and a hardware zero-fill sweep runs after every reset. It sits between the CPU datapath and the load/store unit and takes its width defaults from `CPU_package`.

## Interface
Parameters:
- `DATA_WIDTH`, 16, word width in bits; must be a multiple of `LANE_WIDTH`.
- `LANE_WIDTH`, 8, bits per write-mask lane; `LANES = DATA_WIDTH/LANE_WIDTH`.
- `ADDRESS_WIDTH`, 4, address bus width.
- `DEPTH`, `1<<ADDRESS_WIDTH`, number of implemented words; must satisfy 1 ≤ `DEPTH` ≤ 2^`ADDRESS_WIDTH`.

Ports:
- `Clock`  in  1  single clock; every flop updates on the rising edge.
- `Reset_n`  in  1  reset, synchronous and active-low.
- `Write_Enable`  in  1  write request.
- `write_address`  in  `ADDRESS_WIDTH`  write word address.
- `Write_Mask`  in  `LANES`  per-lane write enable; bit i covers `DATA_WRITE[i*LANE_WIDTH +: LANE_WIDTH]`.
- `DATA_WRITE`  in  `DATA_WIDTH`  write data.
- `Read_Enable`  in  1  read request.
- `read_address`  in  `ADDRESS_WIDTH`  read word address.
- `DATA_READ`  out  `DATA_WIDTH`  registered read data.
- `Read_Valid`  out  1  1-cycle pulse; `DATA_READ` was updated on this edge.
- `Addr_Error`  out  1  1-cycle pulse; an out-of-range access was accepted on the previous edge.
- `Busy`  out  1  high while in reset or during the clear sweep; requests are ignored.

## Operation
- FSM states:
  - `RST`: entered on any edge with `Reset_n`=0.
  - `CLEAR`: entered from `RST` on the first edge with `Reset_n`=1.
  - `READY`: entered when the clear sweep finishes.
- `CLEAR` sweep:
  - Internal counter `clr_addr` starts at 0 and writes all-zero to `mem[clr_addr]` on each edge.
  - It increments by 1 per edge.
  - On the edge that writes `DEPTH-1`, the FSM moves to `READY` and `Busy` falls.
- `RST` and `CLEAR`: `Write_Enable` and `Read_Enable` are ignored. No memory write from the ports, no `Read_Valid`, no `Addr_Error`.
- Write (`READY`, `Write_Enable`=1, `write_address` < `DEPTH`):
  - For each lane i with `Write_Mask[i]`=1, the lane of `mem[write_address]` takes the `DATA_WRITE` lane.
  - Lanes with mask 0 are unchanged.
  - Mask all-zero means no change and no error.
- Read (`READY`, `Read_Enable`=1, `read_address` < `DEPTH`): on the edge, `DATA_READ` ← `mem[read_address]` and `Read_Valid`=1.
- Forwarding: if a read and a write are accepted on the same edge to the same in-range address, `DATA_READ` returns the post-write word. Masked lanes come from `DATA_WRITE`; unmasked lanes come from the old memory contents.
- Out of range (address ≥ `DEPTH`, only possible when `DEPTH` < 2^`ADDRESS_WIDTH`):
  - Write: memory is not modified; `Addr_Error`=1 next cycle.
  - Read: `DATA_READ` ← 0, `Read_Valid`=1, `Addr_Error`=1.
  - If both ports are out of range on the same edge, `Addr_Error` is a single pulse.
- When there is no accepted read, `DATA_READ` holds its last value and `Read_Valid`=0.
- `Addr_Error` and `Read_Valid` are 0 on every edge that has no qualifying event.

## Timing
- Reset values, applied at the first edge with `Reset_n`=0:
  - `DATA_READ`=0, `Read_Valid`=0, `Addr_Error`=0, `Busy`=1.
  - FSM=`RST`, `clr_addr`=0.
  - Memory contents are not touched by `RST` itself; the sweep zeroes them.
- `Reset_n` first sampled high at edge k:
  - The sweep clears address 0 at edge k and address `DEPTH-1` at edge k+`DEPTH`-1.
  - `Busy`=0 after edge k+`DEPTH`-1.
  - The first port request is accepted at edge k+`DEPTH`.
- `Reset_n` low mid-sweep or mid-operation:
  - At that edge all outputs return to reset values and any in-flight read is dropped (no `Read_Valid`).
  - The sweep restarts from address 0 once `Reset_n` rises.
- Read latency: request sampled at edge n; `DATA_READ` and `Read_Valid` are valid after edge n, i.e. during cycle n+1. Back-to-back reads on consecutive edges are supported at full throughput.
- A write at edge n is visible to a read accepted at edge n (forwarding) and to any later read.

## Test plan
- Reset with `DEPTH`=16, `Reset_n` low 2 cycles then high → `Busy`=1 for exactly 16 edges after release. Then read each of addresses 0..15 → `DATA_READ`=0x0000, `Read_Valid` pulses 16 times.
- Full write then read, addr 0x9, `DATA_WRITE`=0xC5A3, mask 2'b11 → read at the next edge returns 0xC5A3 with 1-cycle latency.
- Lane mask: addr 0x9 holds 0xC5A3; write 0x1234 with mask 2'b01 → read returns 0xC534. Write with mask 2'b00 → still 0xC534.
- Same-edge forwarding: addr 0xF holds 0x0009; simultaneous write 0xAB00 mask 2'b10 and read of 0xF → `DATA_READ`=0xAB09 on that read.
- Out of range with `DEPTH`=12: write addr 0xE → `Addr_Error` pulse, memory unchanged. Read addr 0xE → `DATA_READ`=0, `Read_Valid`=1, `Addr_Error`=1.
- Mid-operation reset: write addr 0x1 = 0x000F; assert `Reset_n`=0 on the same edge as a read of 0x1 → no `Read_Valid`, `DATA_READ`=0, `Busy`=1. After the sweep, a read of 0x1 returns 0x0000. Requests issued while `Busy` are ignored.

Source files
------------

// File: rtl/data_memory_ctrl.sv
`default_nettype none
// ============================================================================
// data_memory_ctrl : lane-masked data memory with registered read, same-edge
//                    write-to-read forwarding and a zero-fill sweep after reset
// Revision 1.0
// ============================================================================
module data_memory_ctrl #(
  parameter int DATA_WIDTH    = 16,
  parameter int LANE_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 4,
  parameter int DEPTH         = 1 << ADDRESS_WIDTH
) (
  input  logic                               Clock,
  input  logic                               Reset_n,
  input  logic                               Write_Enable,
  input  logic [ADDRESS_WIDTH-1:0]           write_address,
  input  logic [DATA_WIDTH/LANE_WIDTH-1:0]   Write_Mask,
  input  logic [DATA_WIDTH-1:0]              DATA_WRITE,
  input  logic                               Read_Enable,
  input  logic [ADDRESS_WIDTH-1:0]           read_address,
  output logic [DATA_WIDTH-1:0]              DATA_READ,
  output logic                               Read_Valid,
  output logic                               Addr_Error,
  output logic                               Busy
);

  localparam int LANES = DATA_WIDTH / LANE_WIDTH;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDRESS_WIDTH:0] DEPTH_LIM = (ADDRESS_WIDTH + 1)'(DEPTH);

  typedef enum logic [1:0] {
    RST   = 2'd0,
    CLEAR = 2'd1,
    READY = 2'd2
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic [IDX_W-1:0]       clr_addr;
  logic [DATA_WIDTH-1:0]  mem [DEPTH];

  logic                   ready;
  logic                   clr_last;
  logic                   wr_in_range;
  logic                   rd_in_range;
  logic                   wr_acc;
  logic                   rd_acc;
  logic                   wr_err;
  logic                   rd_err;
  logic                   fwd;
  logic [IDX_W-1:0]       wr_idx;
  logic [IDX_W-1:0]       rd_idx;
  logic [DATA_WIDTH-1:0]  old_word;
  logic [DATA_WIDTH-1:0]  merged;
  logic [DATA_WIDTH-1:0]  rd_word;

  assign ready       = (state == READY);
  assign clr_last    = (clr_addr == IDX_W'(DEPTH - 1));
  assign wr_in_range = ({1'b0, write_address} < DEPTH_LIM);
  assign rd_in_range = ({1'b0, read_address} < DEPTH_LIM);
  assign wr_idx      = write_address[IDX_W-1:0];
  assign rd_idx      = read_address[IDX_W-1:0];

  assign wr_acc = ready && Write_Enable && wr_in_range;
  assign wr_err = ready && Write_Enable && !wr_in_range;
  assign rd_acc = ready && Read_Enable && rd_in_range;
  assign rd_err = ready && Read_Enable && !rd_in_range;

  // Merged word is both the new memory contents and the forwarded read value.
  assign old_word = mem[wr_idx];
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign merged[i*LANE_WIDTH +: LANE_WIDTH] = Write_Mask[i] ?
        DATA_WRITE[i*LANE_WIDTH +: LANE_WIDTH] : old_word[i*LANE_WIDTH +: LANE_WIDTH];
  end

  assign fwd     = wr_acc && rd_acc && (write_address == read_address);
  assign rd_word = fwd ? merged : mem[rd_idx];

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state <= RST;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    Busy       = 1'b1;
    case (state)
      RST:     state_next = clr_last ? READY : CLEAR;
      CLEAR:   if (clr_last) state_next = READY;
      READY:   Busy = 1'b0;
      default: state_next = RST;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      clr_addr   <= '0;
      DATA_READ  <= '0;
      Read_Valid <= 1'b0;
      Addr_Error <= 1'b0;
    end else begin
      Read_Valid <= rd_acc || rd_err;
      Addr_Error <= wr_err || rd_err;
      if (rd_acc) begin
        DATA_READ <= rd_word;
      end else if (rd_err) begin
        DATA_READ <= '0;
      end
      if (!ready) begin
        clr_addr <= clr_addr + IDX_W'(1);
      end
    end
  end

  // No reset on the array itself; the sweep zeroes it, starting on the release edge.
  always_ff @(posedge Clock) begin
    if (Reset_n && !ready) begin
      mem[clr_addr] <= '0;
    end else if (wr_acc) begin
      mem[wr_idx] <= merged;
    end
  end

endmodule
`default_nettype wire
